uart_rx_timing_counter: RTL and testbench



---
 rtl/uart_rx_timing_counter_pkg.sv | 13 +
 rtl/uart_rx_sample_decode.sv | 39 +++
 rtl/uart_rx_timing_counter.sv | 139 +++++++++++++
 tb/tb_uart_rx_timing_counter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_timing_counter_pkg.sv
// Shared types and constants for the UART receive timing counter.
package uart_rx_pkg;

    localparam int MIN_PRESCALE        = 4;
    localparam int PRESCALE_W_DEFAULT  = 6;
    localparam int BIT_CNT_W_DEFAULT   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

endpackage

// File: rtl/uart_rx_sample_decode.sv
// Combinational decode of the mid-bit sample strobes and bit/frame done pulses
// from the current counter position and the effective configuration.
module uart_rx_sample_decode #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  enable,
    input  logic                  cfg_ok,
    input  logic                  cfg_err,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [BIT_CNT_W-1:0]  bit_cnt,
    input  logic [PRESCALE_W-1:0] eff_pre,
    input  logic [BIT_CNT_W-1:0]  eff_fb,
    output logic [2:0]            sample_stb,
    output logic                  bit_done,
    output logic                  frame_done
);

    logic [PRESCALE_W-1:0] mid;
    logic [PRESCALE_W-1:0] last_edge;
    logic [BIT_CNT_W-1:0]  last_bit;
    logic                  active;

    assign mid       = eff_pre >> 1;
    assign last_edge = eff_pre - PRESCALE_W'(1);
    assign last_bit  = eff_fb - BIT_CNT_W'(1);

    // An illegal live config in IDLE would otherwise alias onto edge 0 and
    // produce spurious strobes before cfg_err has had a cycle to register.
    assign active = enable & cfg_ok & ~cfg_err;

    assign sample_stb[0] = active && (edge_cnt == mid - PRESCALE_W'(1));
    assign sample_stb[1] = active && (edge_cnt == mid);
    assign sample_stb[2] = active && (edge_cnt == mid + PRESCALE_W'(1));

    assign bit_done   = active && (edge_cnt == last_edge);
    assign frame_done = bit_done && (bit_cnt == last_bit);

endmodule

// File: rtl/uart_rx_timing_counter.sv
// Oversampling edge/bit counter for the UART receiver: tracks position within
// the bit and frame, and latches prescale/frame length once per frame.
module uart_rx_timing_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEFAULT,
    parameter int BIT_CNT_W  = BIT_CNT_W_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [BIT_CNT_W-1:0]  frame_bits,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic [2:0]            sample_stb,
    output logic                  bit_done,
    output logic                  frame_done,
    output logic                  cfg_err
);

    state_t                state, state_n;
    logic [PRESCALE_W-1:0] edge_n;
    logic [BIT_CNT_W-1:0]  bit_n;
    logic                  err_n;
    logic [PRESCALE_W-1:0] lat_pre, lat_pre_n;
    logic [BIT_CNT_W-1:0]  lat_fb, lat_fb_n;

    logic [PRESCALE_W-1:0] eff_pre;
    logic [BIT_CNT_W-1:0]  eff_fb;
    logic                  eff_ok;
    logic                  live_ok;
    logic                  last_edge;
    logic                  last_bit;

    // Config is only sampled while idle or at a frame boundary.
    assign eff_pre = (state == IDLE) ? prescale   : lat_pre;
    assign eff_fb  = (state == IDLE) ? frame_bits : lat_fb;

    assign live_ok   = (prescale >= PRESCALE_W'(MIN_PRESCALE)) && (frame_bits != '0);
    assign eff_ok    = (eff_pre  >= PRESCALE_W'(MIN_PRESCALE)) && (eff_fb     != '0);
    assign last_edge = (edge_cnt == eff_pre - PRESCALE_W'(1));
    assign last_bit  = (bit_cnt  == eff_fb  - BIT_CNT_W'(1));

    // NOTE: every output is assigned a default first so no path through the
    // case leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_n   = state;
        edge_n    = edge_cnt;
        bit_n     = bit_cnt;
        err_n     = cfg_err;
        lat_pre_n = lat_pre;
        lat_fb_n  = lat_fb;

        if (!enable) begin
            state_n = IDLE;
            edge_n  = '0;
            bit_n   = '0;
            err_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    edge_n = '0;
                    bit_n  = '0;
                    if (live_ok) begin
                        // The visible edge_cnt=0 cycle already counted as the first sample.
                        state_n   = COUNT;
                        edge_n    = PRESCALE_W'(1);
                        err_n     = 1'b0;
                        lat_pre_n = prescale;
                        lat_fb_n  = frame_bits;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                COUNT: begin
                    if (!last_edge) begin
                        edge_n = edge_cnt + PRESCALE_W'(1);
                    end else if (!last_bit) begin
                        edge_n = '0;
                        bit_n  = bit_cnt + BIT_CNT_W'(1);
                    end else begin
                        edge_n = '0;
                        bit_n  = '0;
                        if (live_ok) begin
                            lat_pre_n = prescale;
                            lat_fb_n  = frame_bits;
                        end else begin
                            state_n = IDLE;
                            err_n   = 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    edge_n  = '0;
                    bit_n   = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            edge_cnt <= '0;
            bit_cnt  <= '0;
            cfg_err  <= 1'b0;
            lat_pre  <= '0;
            lat_fb   <= '0;
        end else begin
            state    <= state_n;
            edge_cnt <= edge_n;
            bit_cnt  <= bit_n;
            cfg_err  <= err_n;
            lat_pre  <= lat_pre_n;
            lat_fb   <= lat_fb_n;
        end
    end

    uart_rx_sample_decode #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_CNT_W  (BIT_CNT_W)
    ) u_decode (
        .enable     (enable),
        .cfg_ok     (eff_ok),
        .cfg_err    (cfg_err),
        .edge_cnt   (edge_cnt),
        .bit_cnt    (bit_cnt),
        .eff_pre    (eff_pre),
        .eff_fb     (eff_fb),
        .sample_stb (sample_stb),
        .bit_done   (bit_done),
        .frame_done (frame_done)
    );

endmodule

// File: tb/tb_uart_rx_timing_counter.sv
// Scoreboard bench: a frame-position model predicts every cycle's outputs,
// a separate monitor compares them against the DUT on the falling edge.
module tb_uart_rx_timing_counter;

    localparam int PW = 6;
    localparam int BW = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          enable;
    logic [PW-1:0] prescale;
    logic [BW-1:0] frame_bits;
    logic [PW-1:0] edge_cnt;
    logic [BW-1:0] bit_cnt;
    logic [2:0]    sample_stb;
    logic          bit_done;
    logic          frame_done;
    logic          cfg_err;

    always #5 CLK = ~CLK;

    uart_rx_timing_counter #(
        .PRESCALE_W (PW),
        .BIT_CNT_W  (BW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .enable     (enable),
        .prescale   (prescale),
        .frame_bits (frame_bits),
        .edge_cnt   (edge_cnt),
        .bit_cnt    (bit_cnt),
        .sample_stb (sample_stb),
        .bit_done   (bit_done),
        .frame_done (frame_done),
        .cfg_err    (cfg_err)
    );

    typedef struct packed {
        logic [PW-1:0] edge_v;
        logic [BW-1:0] bit_v;
        logic [2:0]    stb;
        logic          bd;
        logic          fd;
        logic          err;
    } obs_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: position counted as a flat cycle index within the frame.
    bit m_run;
    int m_pos;
    int m_pre;
    int m_fb;
    bit m_err;

    function automatic bit legal(int pre, int fb);
        return (pre >= 4) && (fb != 0);
    endfunction

    function automatic obs_t model_out(bit en, int pre_in, int fb_in);
        obs_t o;
        int   ep, ef, e, b, mid;
        bit   act;
        ep  = m_run ? m_pre : pre_in;
        ef  = m_run ? m_fb  : fb_in;
        e   = m_run ? (m_pos % ep) : 0;
        b   = m_run ? (m_pos / ep) : 0;
        mid = ep / 2;
        act = en && !m_err && legal(ep, ef);
        o.edge_v = PW'(e);
        o.bit_v  = BW'(b);
        for (int k = 0; k < 3; k++) o.stb[k] = act && (e == mid - 1 + k);
        o.bd  = act && (e == ep - 1);
        o.fd  = o.bd && (b == ef - 1);
        o.err = m_err;
        return o;
    endfunction

    task automatic model_step(bit rst, bit en, int pre, int fb);
        if (rst || !en) begin
            m_run = 0;
            m_pos = 0;
            m_err = 0;
        end else if (!m_run) begin
            if (legal(pre, fb)) begin
                m_run = 1;
                m_pos = 1;
                m_pre = pre;
                m_fb  = fb;
                m_err = 0;
            end else begin
                m_err = 1;
            end
        end else begin
            m_pos++;
            if (m_pos == m_pre * m_fb) begin
                m_pos = 0;
                if (legal(pre, fb)) begin
                    m_pre = pre;
                    m_fb  = fb;
                end else begin
                    m_run = 0;
                    m_err = 1;
                end
            end
        end
    endtask

    task automatic drive(bit rst, bit en, int pre, int fb);
        RST        = rst;
        enable     = en;
        prescale   = PW'(pre);
        frame_bits = BW'(fb);
        exp_q.push_back(model_out(en, pre, fb));
        model_step(rst, en, pre, fb);
        @(posedge CLK);
        #1;
    endtask

    task automatic run(int n, int pre, int fb);
        for (int i = 0; i < n; i++) drive(0, 1, pre, fb);
    endtask

    // Monitor: outputs are valid every cycle, so one expectation per falling edge.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{edge_cnt, bit_cnt, sample_stb, bit_done, frame_done, cfg_err};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t got edge=%0d bit=%0d stb=%b bd=%b fd=%b err=%b want edge=%0d bit=%0d stb=%b bd=%b fd=%b err=%b",
                             $time, a.edge_v, a.bit_v, a.stb, a.bd, a.fd, a.err,
                             e.edge_v, e.bit_v, e.stb, e.bd, e.fd, e.err);
                end
            end
        end
    end

    initial begin
        int pre;
        int fb;
        bit en;
        bit rst;
        int r;

        m_run = 0; m_pos = 0; m_pre = 0; m_fb = 0; m_err = 0;
        RST = 1'b1; enable = 1'b0; prescale = '0; frame_bits = '0;
        @(posedge CLK);
        #1;
        drive(1, 0, 0, 0);

        // Full 8x10 frame followed by a few cycles of the next.
        run(84, 8, 10);
        drive(0, 0, 8, 10);

        // Odd prescale.
        run(18, 5, 3);
        drive(0, 0, 5, 3);

        // Prescale change mid-frame applies only from the next frame.
        run(32, 8, 10);
        run(48 + 165, 16, 10);
        drive(0, 0, 8, 10);

        // Drop enable at edge 5, bit 2, then restart.
        run(21, 8, 10);
        drive(0, 0, 8, 10);
        run(20, 8, 10);
        drive(0, 0, 8, 10);

        // Illegal configurations.
        run(3, 3, 10);
        drive(0, 0, 3, 10);
        run(3, 8, 0);
        drive(0, 0, 8, 0);
        drive(0, 0, 8, 10);

        // Reset at edge 6, bit 7 with enable high.
        run(62, 8, 10);
        drive(1, 1, 8, 10);
        run(20, 8, 10);

        // Random configs, frame-boundary illegal configs, enable drops, resets.
        pre = 6; fb = 4;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                r   = int'($urandom_range(0, 19));
                pre = (r == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 20));
                fb  = (r == 1) ? 0 : int'($urandom_range(1, 15));
            end
            en  = ($urandom_range(0, 299) != 0);
            rst = ($urandom_range(0, 499) == 0);
            drive(rst, en, pre, fb);
        end

        @(negedge CLK);
        @(negedge CLK);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
